// File: rtl/regfile_wb_sched_pkg.sv
// Shared widths and constants for the register-file writeback scheduler.
package regfile_wb_sched_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int REG_ZERO       = 0;
endpackage

// File: rtl/regfile_wb_sched_wb_rr_arb2.sv
// Two-requester round-robin arbiter (ALU vs LSU) holding the last-winner pointer.
module wb_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req_alu,
  input  logic req_lsu,
  output logic gnt_alu,
  output logic gnt_lsu
);
  logic last_lsu;

  // Under contention the side that did not win last time gets the port.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_lsu = 1'b0;
    if (!reset) begin
      gnt_alu = req_alu && (!req_lsu || last_lsu);
      gnt_lsu = req_lsu && (!req_alu || !last_lsu);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        last_lsu <= 1'b1;
    else if (gnt_alu) last_lsu <= 1'b0;
    else if (gnt_lsu) last_lsu <= 1'b1;
  end
endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback port scheduler for the register file plus pending-write scoreboard
// used by issue to detect RAW hazards on its two source operands.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid_pi,
  input  logic [ADDR_WIDTH-1:0] alu_dest_pi,
  input  logic [DATA_WIDTH-1:0] alu_data_pi,
  output logic                  alu_ready_po,
  input  logic                  lsu_valid_pi,
  input  logic [ADDR_WIDTH-1:0] lsu_dest_pi,
  input  logic [DATA_WIDTH-1:0] lsu_data_pi,
  output logic                  lsu_ready_po,
  input  logic                  issue_valid_pi,
  input  logic [ADDR_WIDTH-1:0] issue_dest_pi,
  input  logic [ADDR_WIDTH-1:0] src1_pi,
  input  logic [ADDR_WIDTH-1:0] src2_pi,
  output logic                  hazard_po,
  output logic                  sb_conflict_po,
  output logic                  we_po,
  output logic [ADDR_WIDTH-1:0] destReg_po,
  output logic [DATA_WIDTH-1:0] writeData_po
);
  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic                  gnt_alu, gnt_lsu;
  logic [ADDR_WIDTH-1:0] sel_dest;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REGS-1:0]   pending, set_vec, clr_vec;
  logic                  issue_set, conflict_nxt;

  wb_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_alu (alu_valid_pi),
    .req_lsu (lsu_valid_pi),
    .gnt_alu (gnt_alu),
    .gnt_lsu (gnt_lsu)
  );

  assign alu_ready_po = gnt_alu;
  assign lsu_ready_po = gnt_lsu;
  assign sel_dest     = gnt_lsu ? lsu_dest_pi : alu_dest_pi;
  assign sel_data     = gnt_lsu ? lsu_data_pi : alu_data_pi;

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_po        <= 1'b0;
      destReg_po   <= '0;
      writeData_po <= '0;
    end else begin
      we_po <= (gnt_alu || gnt_lsu) && (sel_dest != ZERO_IDX);
      if (gnt_alu || gnt_lsu) begin
        destReg_po   <= sel_dest;
        writeData_po <= sel_data;
      end
    end
  end

  assign issue_set = issue_valid_pi && (issue_dest_pi != ZERO_IDX);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_set) set_vec[issue_dest_pi] = 1'b1;
    if (we_po)     clr_vec[destReg_po]    = 1'b1;
  end

  // A re-reservation racing the retiring write is a legitimate new producer.
  assign conflict_nxt = issue_set && pending[issue_dest_pi] &&
                        !(we_po && (destReg_po == issue_dest_pi));

  always_ff @(posedge clk) begin
    if (reset) begin
      pending        <= '0;
      sb_conflict_po <= 1'b0;
    end else begin
      pending        <= (pending & ~clr_vec) | set_vec;
      sb_conflict_po <= conflict_nxt;
    end
  end

  assign hazard_po = pending[src1_pi] | pending[src2_pi];
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed + randomized bench for regfile_wb_sched against a behavioural model.
module tb_regfile_wb_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic        alu_v, lsu_v, issue_v;
  logic [4:0]  alu_d, lsu_d, issue_d, src1, src2;
  logic [31:0] alu_x, lsu_x;
  logic        alu_rdy, lsu_rdy, hazard, conflict, we;
  logic [4:0]  dest;
  logic [31:0] wdata;

  int passed = 0, total = 0, fails = 0;

  // Reference state: set of registers awaiting a write, who won the last
  // contested/uncontested grant, and what the write port should show.
  bit [31:0]   m_pend;
  bit          m_last_was_lsu;
  bit          m_we, m_conf;
  bit [4:0]    m_dest;
  bit [31:0]   m_data;
  logic        g_alu, g_lsu, obs_haz;

  always #5 clk = ~clk;

  regfile_wb_sched dut (
    .clk(clk), .reset(reset),
    .alu_valid_pi(alu_v), .alu_dest_pi(alu_d), .alu_data_pi(alu_x), .alu_ready_po(alu_rdy),
    .lsu_valid_pi(lsu_v), .lsu_dest_pi(lsu_d), .lsu_data_pi(lsu_x), .lsu_ready_po(lsu_rdy),
    .issue_valid_pi(issue_v), .issue_dest_pi(issue_d), .src1_pi(src1), .src2_pi(src2),
    .hazard_po(hazard), .sb_conflict_po(conflict),
    .we_po(we), .destReg_po(dest), .writeData_po(wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic ea, el, eh;
    #1;
    if (reset) begin
      ea = 1'b0; el = 1'b0;
    end else if (alu_v && lsu_v) begin
      ea = m_last_was_lsu; el = !m_last_was_lsu;
    end else begin
      ea = alu_v; el = lsu_v;
    end
    eh = m_pend[src1] | m_pend[src2];
    chk("alu_ready", alu_rdy, ea);
    chk("lsu_ready", lsu_rdy, el);
    chk("hazard", hazard, eh);
    g_alu = ea; g_lsu = el; obs_haz = hazard;
    @(posedge clk);
    if (reset) begin
      m_pend = '0; m_last_was_lsu = 1'b1;
      m_we = 0; m_dest = 0; m_data = 0; m_conf = 0;
    end else begin
      m_conf = issue_v && issue_d != 0 && m_pend[issue_d] && !(m_we && m_dest == issue_d);
      if (m_we) m_pend[m_dest] = 1'b0;
      if (issue_v && issue_d != 0) m_pend[issue_d] = 1'b1;
      m_we = 1'b0;
      if (ea || el) begin
        m_dest = ea ? alu_d : lsu_d;
        m_data = ea ? alu_x : lsu_x;
        m_we = (m_dest != 0);
        m_last_was_lsu = el;
      end
    end
    #1;
    chk("we", we, m_we);
    chk("dest", dest, m_dest);
    chk("wdata", wdata, m_data);
    chk("conflict", conflict, m_conf);
  endtask

  task automatic idle();
    alu_v = 0; lsu_v = 0; issue_v = 0;
    alu_d = 0; lsu_d = 0; issue_d = 0; alu_x = 0; lsu_x = 0;
    src1 = 0; src2 = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    m_pend = '0; m_last_was_lsu = 1; m_we = 0; m_dest = 0; m_data = 0; m_conf = 0;
    tick(); tick();
    chk("reset_we", we, 0);
    reset = 0;

    // Single ALU write
    alu_v = 1; alu_d = 5; alu_x = 32'hDEADBEEF;
    tick();
    chk("t1_ready", g_alu, 1);
    chk("t1_we", we, 1); chk("t1_dest", dest, 5); chk("t1_data", wdata, 32'hDEADBEEF);
    idle(); tick();
    chk("t1_we_off", we, 0);

    // Contention round-robin from a fresh reset
    reset = 1; tick(); reset = 0;
    alu_v = 1; alu_d = 1; alu_x = 32'h11; lsu_v = 1; lsu_d = 2; lsu_x = 32'h22;
    tick(); chk("rr0", dest, 1);
    tick(); chk("rr1", dest, 2);
    tick(); chk("rr2", dest, 1);
    tick(); chk("rr3", dest, 2);
    idle();

    // x0 discard
    lsu_v = 1; lsu_d = 0; lsu_x = 32'h12345678; issue_v = 1; issue_d = 0;
    tick(); chk("x0_ready", g_lsu, 1); chk("x0_we", we, 0);
    idle(); tick(); chk("x0_haz", obs_haz, 0);

    // Hazard window on register 7
    issue_v = 1; issue_d = 7; tick();
    idle(); src1 = 7; tick(); chk("h7_c1", obs_haz, 1);
    tick();
    alu_v = 1; alu_d = 7; alu_x = 32'h77; tick();
    idle(); src1 = 7; tick(); chk("h7_we", we, 0); chk("h7_c4", obs_haz, 1);
    tick(); chk("h7_c5", obs_haz, 0);

    // Set/clear race then real conflict on register 9
    issue_v = 1; issue_d = 9; tick();
    idle(); alu_v = 1; alu_d = 9; alu_x = 32'h99; tick();
    idle(); issue_v = 1; issue_d = 9; tick(); chk("race_conf", conflict, 0);
    idle(); src1 = 9; tick(); chk("race_pend", obs_haz, 1);
    issue_v = 1; issue_d = 9; tick(); chk("conf_pulse", conflict, 1);
    idle(); tick(); chk("conf_drop", conflict, 0);

    // Reset mid-operation
    issue_v = 1; issue_d = 3; tick();
    idle(); alu_v = 1; alu_d = 4; lsu_v = 1; lsu_d = 6; reset = 1; tick();
    reset = 0; src1 = 3; tick();
    chk("rst_we", we, 1); chk("rst_haz", obs_haz, 0); chk("rst_alu_first", g_alu, 1);
    idle(); tick();

    // Randomized traffic; a held-off requester keeps its request stable
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      if (!(alu_v && !g_alu)) begin
        alu_v = $urandom_range(0, 1); alu_d = 5'($urandom_range(0, 31)); alu_x = $urandom;
      end
      if (!(lsu_v && !g_lsu)) begin
        lsu_v = $urandom_range(0, 1); lsu_d = 5'($urandom_range(0, 31)); lsu_x = $urandom;
      end
      issue_v = $urandom_range(0, 1);
      issue_d = 5'($urandom_range(0, 31));
      src1 = 5'($urandom_range(0, 31));
      src2 = 5'($urandom_range(0, 31));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
